mc_datapath: RTL and testbench
==============================

Name: mc_datapath

Overview:
- Multicycle MIPS datapath: the consumer of the control word driven by main_decoder.
- Holds PC, IR, MDR, A, B, ALUOut, the 32x32 register file, ALU-control decode and ALU.
- Returns Op, Funct and Zero to the controller.
- Drives a single unified memory port shared by instruction fetch and data access.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low; reset==0 clears state immediately.
- MemtoReg, input, 1, register-file write data select: 1=MDR, 0=ALUOut.
- RegDst, input, 1, write register select: 1=IR[15:11], 0=IR[20:16].
- IorD, input, 1, memory address select: 1=ALUOut, 0=PC.
- PCSrc, input, 1, next-PC select: 1=ALUOut, 0=ALUResult.
- ALUSrcB, input, 2, ALU B operand: 00=B, 01=32'd4, 10=SignImm, 11=SignImm<<2.
- ALUSrcA, input, 1, ALU A operand: 1=A, 0=PC.
- IRWrite, input, 1, load IR from mem_rdata.
- MemWrite, input, 1, memory write strobe (passed to mem_we).
- PCWrite, input, 1, unconditional PC load.
- Branch, input, 1, conditional PC load when Zero.
- RegWrite, input, 1, register-file write enable.
- ALUOp, input, 2, 00=add, 01=sub, 10=decode Funct, 11=add.
- Op, output, 6, IR[31:26].
- Funct, output, 6, IR[5:0].
- Zero, output, 1, (ALUResult == 0), combinational.
- mem_addr, output, 32, IorD ? ALUOut : PC.
- mem_wdata, output, 32, register B.
- mem_we, output, 1, equals MemWrite.
- mem_rdata, input, 32, memory read data; combinational read, valid in the same cycle as mem_addr.

Behaviour:
- Reset (reset==0, asynchronous): PC=PC_RESET; IR, MDR, A, B, ALUOut=0; all 32 registers=0. Consequently Op=0, Funct=0, mem_addr=PC_RESET, mem_we=MemWrite.
- Reset asserted mid-instruction aborts the instruction. After release, the first rising edge acts on the reset state.
- Registers updated every edge, no enable: MDR<=mem_rdata; A<=rf[IR[25:21]]; B<=rf[IR[20:16]]; ALUOut<=ALUResult.
- IR<=mem_rdata only when IRWrite=1; otherwise IR holds.
- SignImm = {{16{IR[15]}}, IR[15:0]}.
- SrcA = ALUSrcA ? A : PC. SrcB is selected per ALUSrcB.
- ALU control when ALUOp=10, by Funct: 100000 add; 100010 sub; 100100 and; 100101 or; 101010 slt. Any other Funct yields result 0.
- slt is signed: result is 32'd1 if $signed(SrcA) < $signed(SrcB), else 0.
- Add and sub wrap modulo 2^32; no overflow flag.
- PC update: PC <= PCSrc ? ALUOut : ALUResult when PCWrite | (Branch & Zero). Otherwise PC holds.
- PCWrite=1 together with Branch=1 and Zero=0 still loads PC.
- Register-file write on the edge when RegWrite=1.
  - Address is RegDst ? IR[15:11] : IR[20:16].
  - Data is MemtoReg ? MDR : ALUOut.
  - Writes to register 0 are discarded; reads of register 0 always return 0.
- Read/write same register on the same edge: A/B capture the old value (read-before-write, no bypass).
- IRWrite and PCWrite in the same cycle (fetch): IR captures mem_rdata at the old PC, and PC advances on the same edge.
- MemWrite and IorD are used combinationally. The write address and data are ALUOut and B as held during that cycle.
- Control inputs are taken as stable before each rising edge. There is no internal control state; the FSM lives in main_decoder.

Test Plan:
- Reset then fetch: hold reset=0 for 5 ns, release. mem_rdata=32'h8C08_0004 with IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=0 for one edge -> PC=4, Op=6'b100011, mem_addr=4.
- lw path: rf[0] base=0. Apply ALUSrcA=1, ALUSrcB=10, then IorD=1, then RegWrite=1, MemtoReg=1, RegDst=0, with memory returning 32'h1234_5678 at address 4 -> rf[8]=32'h1234_5678, mem_addr=4 during the access cycle.
- R-type slt: rf[9]=32'hFFFF_FFFF, rf[10]=1, IR=add-style encoding with Funct=101010 and rd=11. Apply ALUOp=10, ALUSrcA=1, ALUSrcB=00, then RegWrite=1, RegDst=1 -> rf[11]=1.
- beq taken vs not taken: A=B=7 with Branch=1, ALUOp=01, PCSrc=1, ALUOut=32'h40 -> PC=32'h40. Repeat with B=8 -> PC unchanged.
- sw and register 0: MemWrite=1, IorD=1, ALUOut=32'h20, B=32'hDEAD_BEEF -> mem_we=1, mem_addr=32'h20, mem_wdata=32'hDEAD_BEEF. Then RegWrite=1 to rd=0 -> rf[0] still reads 0.
- Asynchronous reset mid-instruction: pulse reset=0 between clock edges while PC=32'h40 -> PC=0 and IR=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle MIPS datapath.
// Holds PC, IR, MDR, A, B, ALUOut, the 32x32 register file, ALU-control decode and ALU.
// The control word comes from main_decoder, and Op/Funct/Zero go back to it.
// A single unified memory port serves both instruction fetch and data access.
module mc_datapath #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemtoReg,
  input  logic        RegDst,
  input  logic        IorD,
  input  logic        PCSrc,
  input  logic [1:0]  ALUSrcB,
  input  logic        ALUSrcA,
  input  logic        IRWrite,
  input  logic        MemWrite,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic        RegWrite,
  input  logic [1:0]  ALUOp,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic        Zero,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int DATA_W = 32;

  // Internal ALU operation codes.
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_NONE = 3'd5;

  // ALUOp/Funct to internal ALU operation; unknown R-type functions produce zero.
  function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                            input logic [5:0] funct);
    logic [2:0] ctl;
    ctl = ALU_ADD;
    case (aluop)
      2'b01: ctl = ALU_SUB;
      2'b10: begin
        case (funct)
          6'b100000: ctl = ALU_ADD;
          6'b100010: ctl = ALU_SUB;
          6'b100100: ctl = ALU_AND;
          6'b100101: ctl = ALU_OR;
          6'b101010: ctl = ALU_SLT;
          default:   ctl = ALU_NONE;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // ALU evaluation; add/sub wrap modulo 2^32, slt compares as two's complement.
  function automatic logic [DATA_W-1:0] alu_eval(input logic [2:0]               ctl,
                                                 input logic signed [DATA_W-1:0] x,
                                                 input logic signed [DATA_W-1:0] y);
    logic [DATA_W-1:0] r;
    case (ctl)
      ALU_ADD: r = x + y;
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_SLT: r = (x < y) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] rf [32];

  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        wa3;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] sign_imm;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] pc_next;
  logic [2:0]        alu_ctl;
  logic              pc_en;

  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign Op       = ir[31:26];
  assign Funct    = ir[5:0];
  assign sign_imm = {{16{ir[15]}}, ir[15:0]};

  // Register 0 is hardwired to zero on the read side as well as the write side.
  assign rd1 = (rs == 5'd0) ? '0 : rf[rs];
  assign rd2 = (rt == 5'd0) ? '0 : rf[rt];

  assign wa3 = RegDst ? rd : rt;
  assign wd3 = MemtoReg ? mdr : alu_out;

  assign src_a = ALUSrcA ? a_reg : pc;

  // ALU B operand select.
  always_comb begin
    src_b = b_reg;
    case (ALUSrcB)
      2'b00:   src_b = b_reg;
      2'b01:   src_b = 32'd4;
      2'b10:   src_b = sign_imm;
      default: src_b = {sign_imm[DATA_W-3:0], 2'b00};
    endcase
  end

  assign alu_ctl    = alu_decode(ALUOp, Funct);
  assign alu_result = alu_eval(alu_ctl, src_a, src_b);
  assign Zero       = (alu_result == '0);

  // PCWrite forces the load even when a branch is not taken.
  assign pc_en   = PCWrite | (Branch & Zero);
  assign pc_next = PCSrc ? alu_out : alu_result;

  assign mem_addr  = IorD ? alu_out : pc;
  assign mem_wdata = b_reg;
  assign mem_we    = MemWrite;

  // Program counter: loads on unconditional write or taken branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= PC_RESET;
    end else if (pc_en) begin
      pc <= pc_next;
    end
  end

  // Instruction register: captures the memory word only during fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir <= '0;
    end else if (IRWrite) begin
      ir <= mem_rdata;
    end
  end

  // Non-architectural holding registers between multicycle steps; load every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdr     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
    end else begin
      mdr     <= mem_rdata;
      a_reg   <= rd1;
      b_reg   <= rd2;
      alu_out <= alu_result;
    end
  end

  // Register file write port; A/B see the pre-write value on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (RegWrite && (wa3 != 5'd0)) begin
      rf[wa3] <= wd3;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed testbench for mc_datapath: drives control words cycle by cycle and
// checks observable ports against hand-computed values.
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemtoReg, RegDst, IorD, PCSrc, ALUSrcA, IRWrite;
  logic        MemWrite, PCWrite, Branch, RegWrite;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [5:0]  Op, Funct;
  logic        Zero;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  mc_datapath #(.PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .IorD(IorD), .PCSrc(PCSrc),
    .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .Branch(Branch), .RegWrite(RegWrite), .ALUOp(ALUOp),
    .Op(Op), .Funct(Funct), .Zero(Zero),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    MemtoReg = 0; RegDst = 0; IorD = 0; PCSrc = 0; ALUSrcA = 0; IRWrite = 0;
    MemWrite = 0; PCWrite = 0; Branch = 0; RegWrite = 0;
    ALUSrcB = 2'b00; ALUOp = 2'b00; mem_rdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] instr);
    idle();
    IRWrite = 1; mem_rdata = instr;
    step();
    idle();
  endtask

  // rf[r] <= v through the MDR writeback path; PC untouched.
  task automatic load_reg(input logic [4:0] r, input logic [31:0] v);
    load_ir({6'h00, 5'd0, r, 16'h0000});
    mem_rdata = v;
    step();
    idle();
    RegWrite = 1; MemtoReg = 1; RegDst = 0;
    step();
    idle();
  endtask

  // Reads rf[r] by latching it into B and observing mem_wdata.
  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    load_ir({6'h00, 5'd0, r, 16'h0000});
    step();
    v = mem_wdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    #1 reset = 1'b0;
    #2;
    checks++; if (Op !== 6'h00) begin errors++; $display("FAIL reset_op got %h want 00", Op); end
    checks++; if (Funct !== 6'h00) begin errors++; $display("FAIL reset_funct got %h want 00", Funct); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 00000000", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 00000000", mem_wdata); end
    MemWrite = 1;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL reset_we_hi got %b want 1", mem_we); end
    MemWrite = 0;
    #2;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we_lo got %b want 0", mem_we); end
    reset = 1'b1;
    exp_pc = 32'h0;
  endtask

  task automatic test_fetch();
    idle();
    mem_rdata = 32'h8C08_0004; IRWrite = 1; PCWrite = 1; ALUSrcB = 2'b01;
    step();
    idle();
    #1;
    exp_pc = 32'h4;
    checks++; if (Op !== 6'b100011) begin errors++; $display("FAIL fetch_op got %b want 100011", Op); end
    checks++; if (Funct !== 6'b000100) begin errors++; $display("FAIL fetch_funct got %b want 000100", Funct); end
    checks++; if (mem_addr !== exp_pc) begin errors++; $display("FAIL fetch_pc got %h want %h", mem_addr, exp_pc); end
  endtask

  task automatic test_lw();
    logic [31:0] v;
    step();                                   // decode: A=rf[0], B=rf[8]
    ALUSrcA = 1; ALUSrcB = 2'b10;
    step();                                   // ALUOut = 0 + 4
    IorD = 1; mem_rdata = 32'h1234_5678;
    #1;
    checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL lw_addr got %h want 00000004", mem_addr); end
    step();                                   // MDR captured
    idle();
    RegWrite = 1; MemtoReg = 1; RegDst = 0;
    step();
    idle();
    #1;
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL lw_rbw got %h want 00000000", mem_wdata); end
    read_reg(5'd8, v);
    checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL lw_rf8 got %h want 12345678", v); end
  endtask

  task automatic test_rtype();
    logic [5:0]  fn   [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h2A};
    logic [31:0] expv [6] = '{32'h0, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h1};
    logic        expz [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] v;
    load_reg(5'd9, 32'hFFFF_FFFF);
    load_reg(5'd10, 32'h1);
    for (int i = 0; i < 6; i++) begin
      load_ir({6'h00, 5'd9, 5'd10, 5'd11, 5'd0, fn[i]});
      step();                                 // decode: A=-1, B=1
      ALUOp = 2'b10; ALUSrcA = 1; ALUSrcB = 2'b00;
      #1;
      checks++; if (Zero !== expz[i]) begin errors++; $display("FAIL rtype_zero fn=%h got %b want %b", fn[i], Zero, expz[i]); end
      step();
      idle();
      IorD = 1;
      #1;
      checks++; if (mem_addr !== expv[i]) begin errors++; $display("FAIL rtype_result fn=%h got %h want %h", fn[i], mem_addr, expv[i]); end
    end
    idle();
    RegWrite = 1; RegDst = 1; MemtoReg = 0;   // write slt result to rd=11
    step();
    idle();
    read_reg(5'd11, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL slt_rf11 got %h want 00000001", v); end
  endtask

  task automatic test_sw_r0();
    logic [31:0] v;
    load_reg(5'd15, 32'hDEAD_BEEF);
    load_ir({6'h2B, 5'd0, 5'd15, 16'h0020});
    step();
    ALUSrcA = 1; ALUSrcB = 2'b10;
    step();
    idle();
    MemWrite = 1; IorD = 1;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sw_we got %b want 1", mem_we); end
    checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL sw_addr got %h want 00000020", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata got %h want deadbeef", mem_wdata); end
    step();
    load_ir({6'h23, 5'd0, 5'd0, 16'h0020});
    step();
    ALUSrcA = 1; ALUSrcB = 2'b10;
    step();                                   // ALUOut = 0x20
    idle();
    RegWrite = 1; MemtoReg = 0; RegDst = 0;
    step();
    idle();
    read_reg(5'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL r0_write got %h want 00000000", v); end
  endtask

  task automatic test_beq();
    logic [15:0] imm;
    load_reg(5'd12, 32'd7);
    load_reg(5'd13, 32'd7);
    load_reg(5'd14, 32'd8);
    imm = 16'((32'h40 - exp_pc) >> 2);
    load_ir({6'h04, 5'd12, 5'd13, imm});
    ALUSrcB = 2'b11;
    step();                                   // ALUOut = PC + imm*4 = 0x40
    idle();
    ALUSrcA = 1; ALUOp = 2'b01; Branch = 1; PCSrc = 1;
    #1;
    checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL beq_zero_taken got %b want 1", Zero); end
    step();
    idle();
    #1;
    exp_pc = 32'h40;
    checks++; if (mem_addr !== exp_pc) begin errors++; $display("FAIL beq_taken_pc got %h want %h", mem_addr, exp_pc); end
    load_ir({6'h04, 5'd12, 5'd14, 16'd4});
    ALUSrcB = 2'b11;
    step();                                   // ALUOut = 0x50
    idle();
    ALUSrcA = 1; ALUOp = 2'b01; Branch = 1; PCSrc = 1;
    #1;
    checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL beq_zero_nottaken got %b want 0", Zero); end
    step();
    idle();
    #1;
    checks++; if (mem_addr !== exp_pc) begin errors++; $display("FAIL beq_nottaken_pc got %h want %h", mem_addr, exp_pc); end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    checks++; if (Op !== 6'h04) begin errors++; $display("FAIL async_pre_op got %h want 04", Op); end
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL async_pc got %h want 00000000", mem_addr); end
    checks++; if (Op !== 6'h00) begin errors++; $display("FAIL async_op got %h want 00", Op); end
    checks++; if (Funct !== 6'h00) begin errors++; $display("FAIL async_funct got %h want 00", Funct); end
    #2 reset = 1'b1;
    exp_pc = 32'h0;
    read_reg(5'd12, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL async_rf12 got %h want 00000000", v); end
  endtask

  task automatic test_pcwrite_override();
    idle();
    PCWrite = 1; Branch = 1; PCSrc = 0; ALUSrcA = 0; ALUSrcB = 2'b01;
    #1;
    checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL override_zero got %b want 0", Zero); end
    step();
    idle();
    #1;
    exp_pc = exp_pc + 32'h4;
    checks++; if (mem_addr !== exp_pc) begin errors++; $display("FAIL override_pc got %h want %h", mem_addr, exp_pc); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_lw();
    test_rtype();
    test_sw_r0();
    test_beq();
    test_async_reset();
    test_pcwrite_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
